// File: rtl/filter_pulse_ctrl.sv
// Trapezoidal-filter sequencer: flush/settle the filter, threshold-trigger, report peak/width per pulse.
// Latency: threshold fall -> evt_valid 1 cycle; accept -> armed DEAD_CYC+1 cycles. Optional evt_time via FILTER_CTRL_TIMESTAMP_EN.
// Backpressure: evt_* held stable until evt_valid&&evt_ready; crossings seen meanwhile only bump lost_cnt.
module filter_pulse_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FLUSH_CYC  = 8,
  parameter int SETTLE_CYC = 40,
  parameter int DEAD_CYC   = 16,
  parameter int MAX_WIDTH  = 64,
  parameter int WIDTH_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] thr,
  input  logic signed [DATA_W-1:0] filt_data,
  output logic                     filt_rst_n,
  output logic                     armed,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_peak,
  output logic [WIDTH_W-1:0]       evt_width,
  output logic                     evt_pileup,
  output logic [15:0]              lost_cnt
`ifdef FILTER_CTRL_TIMESTAMP_EN
  ,
  output logic [31:0]              evt_time
`endif
);

  localparam int CNT_W = 16;
  localparam logic [WIDTH_W-1:0] WIDTH_SAT = {WIDTH_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_SETTLE, S_ARMED, S_PEAK, S_REPORT, S_DEAD
  } state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic signed [DATA_W-1:0]   thr_q;
  logic signed [DATA_W-1:0]   peak_q;
  logic [WIDTH_W-1:0]         width_q;
  logic                       prev_above;
  logic                       above;

`ifdef FILTER_CTRL_TIMESTAMP_EN
  logic [31:0] ts;
  logic [31:0] time_q;
`endif

  assign above = filt_data > thr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_FLUSH;
      S_FLUSH:  if (!enable) state_nxt = S_IDLE;
                else if (cnt == CNT_W'(FLUSH_CYC - 1)) state_nxt = S_SETTLE;
      S_SETTLE: if (!enable) state_nxt = S_IDLE;
                else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = S_ARMED;
      S_ARMED:  if (!enable) state_nxt = S_IDLE;
                else if (above) state_nxt = S_PEAK;
      S_PEAK:   if (!enable) state_nxt = S_IDLE;
                else if (!above) state_nxt = S_REPORT;
      // enable is ignored here so a presented event is never withdrawn
      S_REPORT: if (evt_ready) state_nxt = enable ? S_DEAD : S_IDLE;
      S_DEAD:   if (!enable) state_nxt = S_IDLE;
                else if (cnt == CNT_W'(DEAD_CYC - 1)) state_nxt = S_ARMED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      thr_q      <= '0;
      peak_q     <= '0;
      width_q    <= '0;
      prev_above <= 1'b0;
      filt_rst_n <= 1'b0;
      armed      <= 1'b0;
      evt_valid  <= 1'b0;
      evt_peak   <= '0;
      evt_width  <= '0;
      evt_pileup <= 1'b0;
      lost_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      prev_above <= above;
      filt_rst_n <= !(state_nxt == S_IDLE || state_nxt == S_FLUSH);
      armed      <= (state_nxt == S_ARMED);
      evt_valid  <= (state_nxt == S_REPORT);

      if (state_nxt == S_ARMED && state != S_ARMED) thr_q <= thr;

      if (state == S_ARMED && state_nxt == S_PEAK) begin
        peak_q  <= filt_data;
        width_q <= WIDTH_W'(1);
      end else if (state == S_PEAK && state_nxt == S_PEAK) begin
        if (width_q != WIDTH_SAT) width_q <= width_q + WIDTH_W'(1);
        if (filt_data > peak_q) peak_q <= filt_data;
      end

      if (state == S_PEAK && state_nxt == S_REPORT) begin
        evt_peak   <= peak_q;
        evt_width  <= width_q;
        evt_pileup <= (int'(width_q) > MAX_WIDTH);
      end

      // rising crossing while busy: count it as a missed pulse
      if ((state == S_REPORT || state == S_DEAD) && above && !prev_above &&
          lost_cnt != 16'hFFFF)
        lost_cnt <= lost_cnt + 16'd1;
    end
  end

`ifdef FILTER_CTRL_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      time_q   <= '0;
      evt_time <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (state == S_ARMED && state_nxt == S_PEAK) time_q <= ts;
      if (state == S_PEAK && state_nxt == S_REPORT) evt_time <= time_q;
    end
  end
`endif

endmodule

// File: tb/tb_filter_pulse_ctrl.sv
// Bench for filter_pulse_ctrl: directed spec scenarios then random pulses, scored against a timeline model.
module tb_filter_pulse_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] thr = 16'sd100;
  logic signed [15:0] filt_data = '0;
  logic               evt_ready = 1'b0;
  logic               filt_rst_n, armed, evt_valid, evt_pileup;
  logic signed [15:0] evt_peak;
  logic [7:0]         evt_width;
  logic [15:0]        lost_cnt;
`ifdef FILTER_CTRL_TIMESTAMP_EN
  logic [31:0]        evt_time;
`endif

  filter_pulse_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .thr(thr), .filt_data(filt_data),
    .filt_rst_n(filt_rst_n), .armed(armed), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_peak(evt_peak), .evt_width(evt_width), .evt_pileup(evt_pileup), .lost_cnt(lost_cnt)
`ifdef FILTER_CTRL_TIMESTAMP_EN
    , .evt_time(evt_time)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a timeline of the run, in edge numbers ----------------
  typedef struct {
    int          peak;
    int          width;
    int          pileup;
    int unsigned tm;
    int          cyc;
  } ev_t;

  ev_t         q[$];
  int          m_cyc, arm_at, rel_at, thr_m, pk, wd, lost;
  int unsigned ts_m, t0;
  bit          idle, pending, dead, in_pulse, prev_above;
  bit          exp_rstn, exp_armed;

  task automatic model_clear();
    q.delete();
    m_cyc = 0; arm_at = 0; rel_at = 0; thr_m = 0; pk = 0; wd = 0; lost = 0;
    ts_m = 0; t0 = 0;
    idle = 1; pending = 0; dead = 0; in_pulse = 0; prev_above = 0;
    exp_rstn = 0; exp_armed = 0;
  endtask

  task automatic model_step();
    int  fd;
    bit  above;
    ev_t e;
    m_cyc++;
    fd = int'(filt_data);
    above = fd > thr_m;
    if ((pending || dead) && above && !prev_above && lost < 65535) lost++;
    prev_above = above;
    if (idle) begin
      if (enable) begin
        idle = 0; rel_at = m_cyc + 8; arm_at = m_cyc + 48;
      end
    end else if (pending) begin
      if (evt_ready) begin
        pending = 0;
        if (enable) begin dead = 1; arm_at = m_cyc + 16; end
        else idle = 1;
      end
    end else if (!enable) begin
      idle = 1; in_pulse = 0; dead = 0;
    end else if (m_cyc <= arm_at) begin
      if (m_cyc == arm_at) begin thr_m = int'(thr); dead = 0; end
    end else if (!in_pulse) begin
      if (above) begin in_pulse = 1; pk = fd; wd = 1; t0 = ts_m; end
    end else if (above) begin
      wd = (wd < 255) ? wd + 1 : 255;
      if (fd > pk) pk = fd;
    end else begin
      in_pulse = 0; pending = 1;
      e.peak = pk; e.width = wd; e.pileup = (wd > 64) ? 1 : 0; e.tm = t0; e.cyc = m_cyc;
      q.push_back(e);
    end
    ts_m++;
    exp_rstn  = !idle && (m_cyc >= rel_at);
    exp_armed = !idle && !pending && !in_pulse && (m_cyc >= arm_at);
  endtask

  initial model_clear();

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else model_step();
  end

  // ---------------- monitor: compares DUT against model, pops events as presented ----------------
  bit  mon_prev_valid = 0;
  ev_t cur;

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      mon_prev_valid = 0;
      check("rst_peak", evt_peak, 0);
      check("rst_width", evt_width, 0);
      check("rst_pileup", evt_pileup, 0);
    end
    check("filt_rst_n", filt_rst_n, exp_rstn);
    check("armed", armed, exp_armed);
    check("evt_valid", evt_valid, pending);
    check("lost_cnt", lost_cnt, lost);
    if (reset && evt_valid && !mon_prev_valid) begin
      check("evt_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        cur = q.pop_front();
        check("evt_peak", evt_peak, cur.peak);
        check("evt_width", evt_width, cur.width);
        check("evt_pileup", evt_pileup, cur.pileup);
        check("evt_cycle", m_cyc, cur.cyc);
`ifdef FILTER_CTRL_TIMESTAMP_EN
        check("evt_time", evt_time, cur.tm);
`endif
      end
    end else if (reset && evt_valid) begin
      check("hold_peak", evt_peak, cur.peak);
      check("hold_width", evt_width, cur.width);
      check("hold_pileup", evt_pileup, cur.pileup);
    end
    if (reset) mon_prev_valid = evt_valid;
  end

  // ---------------- stimulus ----------------
  int off = 0;

  task automatic drive(int v, int n);
    repeat (n) begin
      @(negedge clk);
      filt_data = 16'(v);
    end
  endtask

  task automatic wait_valid(string name, int budget);
    int k = 0;
    while (!evt_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, evt_valid, 1);
  endtask

  task automatic rnd_cycle(int v);
    @(negedge clk);
    filt_data = 16'(v);
    evt_ready = ($urandom_range(0, 3) != 0);
    if (!enable) begin
      off--;
      if (off <= 0) enable = 1'b1;
    end else if (armed && $urandom_range(0, 149) == 0) begin
      enable = 1'b0;
      off = 3;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // 1: bring-up sequence
    enable = 1'b1;
    drive(0, 60);
    check("t1_armed", armed, 1);
    // 2: single pulse
    evt_ready = 1'b1;
    drive(0, 1); drive(50, 1); drive(150, 1); drive(300, 1);
    drive(200, 1); drive(120, 1); drive(90, 1);
    wait_valid("t2_valid", 5);
    check("t2_peak", evt_peak, 300);
    check("t2_width", evt_width, 4);
    check("t2_pileup", evt_pileup, 0);
    drive(0, 30);
    // 3: backpressure with a missed pulse
    evt_ready = 1'b0;
    drive(200, 3); drive(0, 1);
    wait_valid("t3_valid", 5);
    drive(0, 2); drive(250, 2); drive(0, 16);
    check("t3_valid_held", evt_valid, 1);
    check("t3_peak", evt_peak, 200);
    check("t3_width", evt_width, 3);
    check("t3_lost", lost_cnt, 1);
    evt_ready = 1'b1;
    drive(0, 30);
    // 4: long pulses, pile-up and width saturation
    drive(500, 70); drive(0, 1);
    wait_valid("t4_valid_a", 5);
    check("t4_width_a", evt_width, 70);
    check("t4_pileup_a", evt_pileup, 1);
    drive(0, 30);
    drive(500, 300); drive(0, 1);
    wait_valid("t4_valid_b", 5);
    check("t4_width_b", evt_width, 255);
    check("t4_peak_b", evt_peak, 500);
    drive(0, 30);
    // 5: enable drop mid-pulse discards it
    drive(400, 5);
    @(negedge clk);
    enable = 1'b0;
    filt_data = '0;
    @(negedge clk);
    check("t5_rstn", filt_rst_n, 0);
    check("t5_valid", evt_valid, 0);
    drive(0, 10);
    enable = 1'b1;
    drive(0, 60);
    check("t5_rearmed", armed, 1);
    // 6: async reset while an event is waiting
    evt_ready = 1'b0;
    drive(300, 4); drive(0, 1);
    wait_valid("t6_valid", 5);
    drive(0, 3);
    #2 reset = 1'b0;
    #1;
    check("t6_valid", evt_valid, 0);
    check("t6_peak", evt_peak, 0);
    check("t6_lost", lost_cnt, 0);
    check("t6_rstn", filt_rst_n, 0);
    @(negedge clk);
    reset = 1'b1;
    evt_ready = 1'b1;
    drive(0, 60);
    check("t6_rearmed", armed, 1);
    // random pulse trains, thresholds and backpressure
    for (int s = 0; s < 40; s++) begin
      int t;
      t = int'($urandom_range(0, 400)) - 200;
      thr = 16'(t);
      for (int i = 0; i < int'($urandom_range(1, 90)); i++)
        rnd_cycle(t + int'($urandom_range(1, 500)));
      for (int i = 0; i < int'($urandom_range(1, 40)); i++)
        rnd_cycle(t - int'($urandom_range(0, 300)));
    end
    enable = 1'b1;
    evt_ready = 1'b1;
    drive(-30000, 60);
    check("drain_queue", q.size(), 0);
    check("drain_valid", evt_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
